debug_frame_tx: RTL and testbench

DEBUG_FRAME_TX -- requirements
Module: debug_frame_tx

---
 rtl/debug_pkg.sv | 22 ++
 rtl/debug_frame_tx.sv | 146 ++++++++++++++
 tb/tb_debug_frame_tx.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_pkg.sv
// Shared definitions for the debug UART framing path (transmit framer and receive-side parser).
// State codes are plain constants so legacy code that compares raw values keeps working.
package debug_pkg;

    typedef logic [2:0] dbg_state_t;

    localparam dbg_state_t ST_IDLE    = 3'd0;
    localparam dbg_state_t ST_LOAD    = 3'd1;
    localparam dbg_state_t ST_SEND    = 3'd2;
    localparam dbg_state_t ST_WAIT_HI = 3'd3;
    localparam dbg_state_t ST_WAIT_LO = 3'd4;
    localparam dbg_state_t ST_NEXT    = 3'd5;
    localparam dbg_state_t ST_DONE    = 3'd6;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

    // Bytes on the wire for one frame: payload plus SOF, length and checksum when framed.
    function automatic int unsigned frame_bytes(input int unsigned n, input bit framed);
        return framed ? n + 32'd3 : n;
    endfunction

endpackage

// File: rtl/debug_frame_tx.sv
// Serialises a wide payload into UART bytes, optionally wrapped as SOF/length/payload/checksum,
// handshaking each byte on the transmitter's busy rise and fall.
module debug_frame_tx
    import debug_pkg::*;
#(
    parameter int unsigned NUM_BYTES = 220,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          FRAMED    = 1'b1,
    parameter logic [7:0]  SOF_BYTE  = SOF_DEFAULT
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   sendSignal,
    input  logic [NUM_BYTES*8-1:0] sendData,
    input  logic                   tx_busy,
    output logic                   wr_uart,
    output logic [7:0]             w_data,
    output logic                   dataSent,
    output logic                   busy
);

    localparam int unsigned PW       = NUM_BYTES * 8;
    localparam int unsigned CW       = $clog2(NUM_BYTES + 3);
    localparam int unsigned LAST_IDX = frame_bytes(NUM_BYTES, FRAMED) - 1;
    localparam logic [7:0]  LEN_BYTE = 8'(NUM_BYTES);

    dbg_state_t      state_q, state_d;
    logic [PW-1:0]   shreg_q, shreg_d;
    logic [CW-1:0]   idx_q,   idx_d;
    logic [7:0]      csum_q,  csum_d;
    logic            wr_q,    wr_d;
    logic [7:0]      wdata_q, wdata_d;

    logic            is_sof;
    logic            is_len;
    logic            is_csum;
    logic            is_payload;
    logic [7:0]      payload_byte;
    logic [7:0]      cur_byte;

    // The byte index only classifies the frame slot; payload bytes always come from the shifter head.
    always_comb begin
        is_sof  = 1'b0;
        is_len  = 1'b0;
        is_csum = 1'b0;
        if (FRAMED) begin
            is_sof  = (idx_q == CW'(0));
            is_len  = (idx_q == CW'(1));
            is_csum = (idx_q == CW'(LAST_IDX));
        end
        is_payload   = !(is_sof || is_len || is_csum);
        payload_byte = MSB_FIRST ? shreg_q[PW-1 -: 8] : shreg_q[7:0];
        if (is_sof) begin
            cur_byte = SOF_BYTE;
        end else if (is_len) begin
            cur_byte = LEN_BYTE;
        end else if (is_csum) begin
            cur_byte = csum_q;
        end else begin
            cur_byte = payload_byte;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        csum_d  = csum_q;
        wr_d    = 1'b0;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (sendSignal) begin
                    shreg_d = sendData;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                idx_d   = '0;
                csum_d  = '0;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (!tx_busy) begin
                    wr_d    = 1'b1;
                    wdata_d = cur_byte;
                    if (is_len || is_payload) begin
                        csum_d = csum_q ^ cur_byte;
                    end
                    if (is_payload) begin
                        shreg_d = MSB_FIRST ? (shreg_q << 8) : (shreg_q >> 8);
                    end
                    state_d = ST_WAIT_HI;
                end
            end
            ST_WAIT_HI: begin
                if (tx_busy) begin
                    state_d = ST_WAIT_LO;
                end
            end
            ST_WAIT_LO: begin
                if (!tx_busy) begin
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (idx_q == CW'(LAST_IDX)) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + CW'(1);
                    state_d = ST_SEND;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
            csum_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            csum_q  <= csum_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
        end
    end

    assign wr_uart  = wr_q;
    assign w_data   = wdata_q;
    assign dataSent = (state_q == ST_DONE);
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_debug_frame_tx.sv
// Scoreboard bench: three framer configurations, each with a UART busy model; expected bytes are
// queued at request time and popped by a negedge monitor.
module tb_debug_frame_tx;

    localparam int DONE_TOK = 256;
    localparam int UART_CYC = 10;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [2:0]   ss = '0;
    logic [2:0]   hold = '0;
    logic [2:0]   wr;
    logic [2:0]   ds;
    logic [2:0]   bsy;
    logic [2:0]   txb;
    logic [7:0]   wd [3];
    logic [31:0]  da = '0;
    logic [31:0]  db = '0;
    logic [1759:0] dc = '0;

    int     ucnt [3];
    int     exp_q [3][$];
    int     wr_cnt [3];
    logic [2:0] prev_wr = '0;
    logic   rst_q = 1'b0;
    int     n_cmp = 0;
    int     n_bad = 0;
    int     tmo_cnt = 0;
    bit     stim_done = 1'b0;
    bit     fin = 1'b0;

    always #5 clk = ~clk;

    debug_frame_tx #(.NUM_BYTES(4), .MSB_FIRST(1'b1), .FRAMED(1'b1)) u_a (
        .clock(clk), .reset(rst), .sendSignal(ss[0]), .sendData(da), .tx_busy(txb[0]),
        .wr_uart(wr[0]), .w_data(wd[0]), .dataSent(ds[0]), .busy(bsy[0]));

    debug_frame_tx #(.NUM_BYTES(4), .MSB_FIRST(1'b0), .FRAMED(1'b0)) u_b (
        .clock(clk), .reset(rst), .sendSignal(ss[1]), .sendData(db), .tx_busy(txb[1]),
        .wr_uart(wr[1]), .w_data(wd[1]), .dataSent(ds[1]), .busy(bsy[1]));

    debug_frame_tx #(.NUM_BYTES(220), .MSB_FIRST(1'b1), .FRAMED(1'b1)) u_c (
        .clock(clk), .reset(rst), .sendSignal(ss[2]), .sendData(dc), .tx_busy(txb[2]),
        .wr_uart(wr[2]), .w_data(wd[2]), .dataSent(ds[2]), .busy(bsy[2]));

    // UART model: busy for UART_CYC cycles after each write strobe; hold forces busy externally.
    always @(posedge clk) begin
        rst_q <= rst;
        for (int i = 0; i < 3; i++) begin
            if (wr[i]) ucnt[i] <= UART_CYC;
            else if (ucnt[i] > 0) ucnt[i] <= ucnt[i] - 1;
        end
    end
    assign txb[0] = (ucnt[0] != 0) || hold[0];
    assign txb[1] = (ucnt[1] != 0) || hold[1];
    assign txb[2] = (ucnt[2] != 0) || hold[2];

    task automatic chk(input string nm, input int i, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s inst%0d: got 0x%0h, want 0x%0h", nm, i, act, req);
        end
    endtask

    always @(negedge clk) begin
        int e;
        for (int i = 0; i < 3; i++) begin
            if (rst_q) begin
                chk("reset_wr_uart", i, int'(wr[i]), 0);
                chk("reset_dataSent", i, int'(ds[i]), 0);
                chk("reset_busy", i, int'(bsy[i]), 0);
                chk("reset_w_data", i, int'(wd[i]), 0);
            end
            if (hold[i]) chk("wr_while_tx_busy_held", i, int'(wr[i]), 0);
            if (wr[i]) begin
                chk("adjacent_wr_uart", i, int'(prev_wr[i]), 0);
                if (exp_q[i].size() > 0) e = exp_q[i].pop_front();
                else e = -1;
                chk("tx_byte", i, int'(wd[i]), e);
                wr_cnt[i]++;
            end
            if (ds[i]) begin
                if (exp_q[i].size() > 0) e = exp_q[i].pop_front();
                else e = -1;
                chk("dataSent_position", i, e, DONE_TOK);
                chk("busy_at_dataSent", i, int'(bsy[i]), 1);
            end
            prev_wr[i] = wr[i];
        end
        if (stim_done && !fin) begin
            fin = 1'b1;
            for (int i = 0; i < 3; i++) chk("queue_drained", i, exp_q[i].size(), 0);
            chk("wait_timeouts", 0, tmo_cnt, 0);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end
    end

    // Reference frame: bytes taken from the payload by byte number, ordered per config.
    task automatic push_frame(input int i, input logic [1759:0] d);
        int n;
        bit framed;
        bit msb;
        int cs;
        int b;
        n      = (i == 2) ? 220 : 4;
        framed = (i != 1);
        msb    = (i != 1);
        cs     = n & 255;
        if (framed) begin
            exp_q[i].push_back(8'hA5);
            exp_q[i].push_back(n & 255);
        end
        for (int k = 0; k < n; k++) begin
            b  = int'(d[8 * (msb ? (n - 1 - k) : k) +: 8]);
            cs = cs ^ b;
            exp_q[i].push_back(b);
        end
        if (framed) exp_q[i].push_back(cs);
        exp_q[i].push_back(DONE_TOK);
    endtask

    task automatic set_data(input int i, input logic [1759:0] d);
        case (i)
            0: da = d[31:0];
            1: db = d[31:0];
            default: dc = d;
        endcase
    endtask

    task automatic pulse(input int i);
        ss[i] = 1'b1;
        @(posedge clk); #1;
        ss[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i, input int lim);
        int k = 0;
        while (bsy[i] && k < lim) begin
            @(posedge clk); #1;
            k++;
        end
        if (bsy[i]) begin
            tmo_cnt++;
            $display("FAIL wait_idle inst%0d: still busy after %0d cycles", i, lim);
        end
    endtask

    task automatic wait_wr(input int i, input int target, input int lim);
        int k = 0;
        while (wr_cnt[i] < target && k < lim) begin
            @(posedge clk); #1;
            k++;
        end
        if (wr_cnt[i] < target) begin
            tmo_cnt++;
            $display("FAIL wait_wr inst%0d: %0d strobes, want %0d", i, wr_cnt[i], target);
        end
    endtask

    function automatic logic [1759:0] rnd_data();
        logic [1759:0] r;
        for (int k = 0; k < 55; k++) r[32 * k +: 32] = $urandom;
        return r;
    endfunction

    task automatic run_frame(input int i, input logic [1759:0] d, input bit mid, input bit dreq,
                             input int holdc);
        int k;
        int base;
        wait_idle(i, 8000);
        if (holdc > 0) hold[i] = 1'b1;
        set_data(i, d);
        push_frame(i, d);
        pulse(i);
        if (holdc > 0) begin
            repeat (holdc - 1) begin @(posedge clk); #1; end
            hold[i] = 1'b0;
        end
        if (mid) begin
            base = wr_cnt[i];
            wait_wr(i, base + 2, 2000);
            set_data(i, ~d);
            pulse(i);
        end
        if (dreq) begin
            k = 0;
            while (!ds[i] && k < 8000) begin
                @(posedge clk); #1;
                k++;
            end
            if (!ds[i]) begin
                tmo_cnt++;
                $display("FAIL wait_dataSent inst%0d: no pulse", i);
            end else begin
                pulse(i);
            end
        end
        wait_idle(i, 8000);
    endtask

    initial begin
        int base;
        logic [1759:0] d;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        run_frame(0, {1728'd0, 32'h11223344}, 1'b0, 1'b0, 0);
        run_frame(1, {1728'd0, 32'h11223344}, 1'b0, 1'b0, 0);
        run_frame(0, rnd_data(), 1'b1, 1'b1, 0);
        run_frame(0, rnd_data(), 1'b0, 1'b0, 50);

        // Abort a frame after its third byte; the remaining expectations are discarded.
        wait_idle(0, 8000);
        d = rnd_data();
        set_data(0, d);
        push_frame(0, d);
        base = wr_cnt[0];
        pulse(0);
        wait_wr(0, base + 3, 2000);
        rst = 1'b1;
        exp_q[0].delete();
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        run_frame(0, rnd_data(), 1'b0, 1'b0, 0);

        run_frame(2, rnd_data(), 1'b0, 1'b0, 0);
        run_frame(2, rnd_data(), 1'b1, 1'b0, 0);

        for (int r = 0; r < 6; r++) begin
            int i;
            i = $urandom_range(0, 2);
            run_frame(i, rnd_data(), 1'b0, 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 1) != 0) ? $urandom_range(1, 20) : 0);
        end

        repeat (5) @(posedge clk);
        #1 stim_done = 1'b1;
    end

endmodule
